bless_inject_queue: RTL and testbench
=====================================

Name: bless_inject_queue

Overview:
- Local-port injection stage for the 5-port BLESS bufferless router. It sits between the core/NI request interface and router input port 4 (data_in_4).
- Buffers core packet requests in a small FIFO and formats each one into a DATA_WIDTH flit.
- Drives a flit onto the local port only when the router has a free output slot, since a bufferless router cannot accept a fifth flit when all four network inputs are occupied.
- Also tracks injection starvation.

Parameters:
- DATA_WIDTH, 160: flit width; must equal the router flit width.
- DEPTH, 4: request FIFO entries, power of two, minimum 2.
- MY_X, 0: this node's x coordinate (3 bits).
- MY_Y, 0: this node's y coordinate (3 bits).
- STARVE_TH, 16: consecutive blocked cycles before starve is asserted.

Ports:
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- req_valid  in  1: core offers a request.
- req_ready  out  1: FIFO can accept a request this cycle.
- req_dst_x  in  3: destination x.
- req_dst_y  in  3: destination y.
- req_payload  in  128: flit payload.
- net_busy  in  4: valid flags of the flits on router data_in_0..3 this cycle.
- data_out_4  out  DATA_WIDTH: flit to router data_in_4; all-zero when idle.
- inj_fire  out  1: router takes data_out_4 this cycle.
- starve  out  1: injection starvation flag.
- err_loopback  out  1: one-cycle pulse when a request with dst == (MY_X, MY_Y) is dropped.
- inj_count  out  16: saturating count of injected flits.

Behaviour:
- Flit layout, MSB first:
  - seq [159:152]
  - dst_x [151:149]
  - dst_y [148:146]
  - rsvd [145:140], driven 0
  - vld [139:137]: 3'd1 marks a valid flit, 3'd0 an empty slot
  - flit_num [136:134] = 0
  - src_x [133:131] = MY_X
  - src_y [130:128] = MY_Y
  - payload [127:0]
- Reset values (asynchronous): FIFO empty, data_out_4 = 0, seq = 0, inj_count = 0, starve = 0, err_loopback = 0, blocked counter = 0.
- req_ready = FIFO not full. This is combinational from registered occupancy only and never depends on req_valid.
- Request accept occurs when req_valid & req_ready.
  - Loopback requests are dropped: err_loopback is 1 the next cycle and nothing is written.
  - All other accepted requests are written to the FIFO.
- Output stage: data_out_4 is a register that holds the head flit. An out-stage flit is valid when data_out_4[139:137] != 0.
- inj_fire = out valid & (popcount(net_busy) < 4). This is combinational and is the only net_busy-to-output path.
- On a clock edge:
  - If inj_fire, or the out stage is empty, load the next flit from the FIFO head. Otherwise hold data_out_4 unchanged.
  - Bypass: with an empty FIFO and an empty or firing out stage, an accepted request loads directly into data_out_4. Minimum latency is 1 cycle from accept to data_out_4.
  - If the out stage empties and no entry is available, data_out_4 becomes all-zero.
- seq is stamped when a flit is loaded into the out stage. It increments after every load and wraps 255 to 0.
- inj_count increments on inj_fire and saturates at 16'hFFFF.
- Starvation:
  - The blocked counter increments on each cycle with out valid & ~inj_fire, and clears on inj_fire or when the out stage is empty.
  - starve is a register set when the counter reaches STARVE_TH and cleared on the cycle after inj_fire.
  - The counter saturates at STARVE_TH.
- Simultaneous request accept and out-stage load on a full FIFO: the FIFO is read and written in the same cycle. Occupancy is unchanged and ordering is preserved.
- Reset mid-operation: all queued flits are discarded. No partial flit is emitted; data_out_4 is 0 while reset is high.

Decomposition:
- Shared package (global.vh additions):
  - DATA_WIDTH
  - flit field MSB/LSB constants (SEQ, DST_X, DST_Y, VLD, FLIT_NUM, SRC_X, SRC_Y, PAYLOAD)
  - VLD_EMPTY = 3'd0 and VLD_FLIT = 3'd1
  - coordinate width of 3
- One natural sub-module: bless_sync_fifo. It is parameterised by width and depth, with push/pop, full/empty, and simultaneous push+pop when full. The top level adds formatting, the output stage, and arbitration.

Test Plan:
- Single request, dst (3,4), payload DEAD_BEEF_0000_0001, net_busy = 4'b0000 → data_out_4 the next cycle with seq 0, vld 1, src (MY_X, MY_Y); inj_fire = 1 that cycle; inj_count = 1.
- net_busy = 4'b1111 held for 20 cycles with one queued flit → data_out_4 is stable, inj_fire = 0, starve rises after STARVE_TH = 16 blocked cycles. Then net_busy = 4'b0111 → inj_fire = 1 and starve = 0 on the next cycle.
- Push 5 requests back-to-back with DEPTH = 4 and net_busy = 4'b1111 → out stage plus 4 entries fill, req_ready = 0. After release, flits emerge in order with seq 0..4.
- Request with dst == (MY_X, MY_Y) → err_loopback pulses for 1 cycle, no flit emitted, inj_count unchanged.
- 300 injections with net_busy = 0 → seq wraps from 255 to 0; inj_count = 300.
- Assert reset mid-stream with 3 queued flits → data_out_4 = 0 immediately (asynchronous), req_ready = 1, and seq restarts at 0 after reset is released.

Source files
------------

// File: rtl/bless_inject_queue_pkg.sv
// Shared constants for the BLESS local-port injection stage.
// Covers the flit field map, valid encodings and coordinate widths.
package bless_inject_queue_pkg;

    localparam int DATA_WIDTH = 160;
    localparam int COORD_W    = 3;
    localparam int PAYLOAD_W  = 128;
    localparam int SEQ_W      = 8;

    localparam int SEQ_MSB      = 159;
    localparam int SEQ_LSB      = 152;
    localparam int DST_X_MSB    = 151;
    localparam int DST_X_LSB    = 149;
    localparam int DST_Y_MSB    = 148;
    localparam int DST_Y_LSB    = 146;
    localparam int VLD_MSB      = 139;
    localparam int VLD_LSB      = 137;
    localparam int FLIT_NUM_MSB = 136;
    localparam int FLIT_NUM_LSB = 134;
    localparam int SRC_X_MSB    = 133;
    localparam int SRC_X_LSB    = 131;
    localparam int SRC_Y_MSB    = 130;
    localparam int SRC_Y_LSB    = 128;
    localparam int PAYLOAD_MSB  = 127;
    localparam int PAYLOAD_LSB  = 0;

    localparam logic [2:0] VLD_EMPTY = 3'd0;
    localparam logic [2:0] VLD_FLIT  = 3'd1;

    // Queued request entry: {dst_x, dst_y, payload}; seq and source are added on load.
    localparam int ENTRY_W = 2 * COORD_W + PAYLOAD_W;

endpackage

// File: rtl/bless_inject_queue_if.sv
// Core/NI request handshake into the injection queue.
interface bless_inject_queue_if;
    import bless_inject_queue_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [COORD_W-1:0]   req_dst_x;
    logic [COORD_W-1:0]   req_dst_y;
    logic [PAYLOAD_W-1:0] req_payload;

    modport master (output req_valid, req_dst_x, req_dst_y, req_payload, input req_ready);
    modport slave  (input req_valid, req_dst_x, req_dst_y, req_payload, output req_ready);

endinterface

// File: rtl/bless_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; a push is accepted while full if a pop
// happens in the same cycle, so occupancy holds and order is kept.
module bless_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bless_inject_queue.sv
// Local-port injection stage for the 5-port BLESS router: queues core requests,
// formats them into flits and injects only when a router output slot is free.
module bless_inject_queue
    import bless_inject_queue_pkg::*;
#(
    parameter int                 DATA_WIDTH = bless_inject_queue_pkg::DATA_WIDTH,
    parameter int                 DEPTH      = 4,
    parameter logic [COORD_W-1:0] MY_X       = '0,
    parameter logic [COORD_W-1:0] MY_Y       = '0,
    parameter int                 STARVE_TH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bless_inject_queue_if.slave   req,
    input  logic [3:0]            net_busy,
    output logic [DATA_WIDTH-1:0] data_out_4,
    output logic                  inj_fire,
    output logic                  starve,
    output logic                  err_loopback,
    output logic [15:0]           inj_count
);

    localparam int BLK_W = $clog2(STARVE_TH + 1);

    logic [ENTRY_W-1:0] req_entry_p0;
    logic [ENTRY_W-1:0] head_entry_p0;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               accept;
    logic               loopback;
    logic               wr_ok;
    logic               load_slot;
    logic               bypass;
    logic               vld_p1;
    logic               blocked;
    logic [SEQ_W-1:0]   seq;
    logic [BLK_W-1:0]   blk_cnt;

    function automatic logic [DATA_WIDTH-1:0] fmt_flit(input logic [SEQ_W-1:0] s,
                                                       input logic [ENTRY_W-1:0] e);
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[SEQ_MSB:SEQ_LSB]         = s;
        f[DST_X_MSB:DST_X_LSB]     = e[ENTRY_W-1 -: COORD_W];
        f[DST_Y_MSB:DST_Y_LSB]     = e[PAYLOAD_W +: COORD_W];
        f[VLD_MSB:VLD_LSB]         = VLD_FLIT;
        f[SRC_X_MSB:SRC_X_LSB]     = MY_X;
        f[SRC_Y_MSB:SRC_Y_LSB]     = MY_Y;
        f[PAYLOAD_MSB:PAYLOAD_LSB] = e[PAYLOAD_W-1:0];
        return f;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Request side: accept, loopback filter, and bypass when nothing is queued ahead
    assign req.req_ready = ~fifo_full;
    assign accept        = req.req_valid & req.req_ready;
    assign loopback      = accept & (req.req_dst_x == MY_X) & (req.req_dst_y == MY_Y);
    assign wr_ok         = accept & ~loopback;
    assign req_entry_p0  = {req.req_dst_x, req.req_dst_y, req.req_payload};

    // Out stage: a fourth busy input leaves the router no free slot for us
    assign vld_p1    = (data_out_4[VLD_MSB:VLD_LSB] != VLD_EMPTY);
    assign inj_fire  = vld_p1 & ~(&net_busy);
    assign load_slot = inj_fire | ~vld_p1;
    assign bypass    = wr_ok & fifo_empty & load_slot;
    assign fifo_push = wr_ok & ~bypass;
    assign fifo_pop  = load_slot & ~fifo_empty;
    assign blocked   = vld_p1 & ~inj_fire;

    bless_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (req_entry_p0),
        .pop   (fifo_pop),
        .rdata (head_entry_p0),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_4   <= '0;
            seq          <= '0;
            inj_count    <= '0;
            starve       <= 1'b0;
            err_loopback <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            err_loopback <= loopback;
            if (load_slot) begin
                if (!fifo_empty) begin
                    data_out_4 <= fmt_flit(seq, head_entry_p0);
                    seq        <= seq + 1'b1;
                end else if (bypass) begin
                    data_out_4 <= fmt_flit(seq, req_entry_p0);
                    seq        <= seq + 1'b1;
                end else begin
                    data_out_4 <= '0;
                end
            end
            if (inj_fire) inj_count <= sat_inc16(inj_count);
            // starve rises on the same edge the blocked count reaches the threshold
            if (blocked) begin
                if (blk_cnt != BLK_W'(STARVE_TH)) blk_cnt <= blk_cnt + 1'b1;
                if (blk_cnt >= BLK_W'(STARVE_TH - 1)) starve <= 1'b1;
            end else begin
                blk_cnt <= '0;
            end
            if (inj_fire) starve <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bless_inject_queue.sv
// Scoreboard bench for bless_inject_queue: stimulus queues expected flits,
// a negedge monitor checks every injected flit in order.
module tb_bless_inject_queue;
    import bless_inject_queue_pkg::*;

    localparam logic [2:0] MY_X = 3'd2;
    localparam logic [2:0] MY_Y = 3'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    net_busy = 4'b0000;
    logic [159:0]  data_out_4;
    logic          inj_fire;
    logic          starve;
    logic          err_loopback;
    logic [15:0]   inj_count;

    bless_inject_queue_if ifc ();

    bless_inject_queue #(
        .DATA_WIDTH (160),
        .DEPTH      (4),
        .MY_X       (MY_X),
        .MY_Y       (MY_Y),
        .STARVE_TH  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (ifc.slave),
        .net_busy     (net_busy),
        .data_out_4   (data_out_4),
        .inj_fire     (inj_fire),
        .starve       (starve),
        .err_loopback (err_loopback),
        .inj_count    (inj_count)
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           errors  = 0;
    logic [159:0] sb[$];
    logic [7:0]   mseq = 8'd0;
    logic [159:0] held;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] exp_flit(input logic [7:0] s, input logic [2:0] dx,
                                              input logic [2:0] dy, input logic [127:0] pl);
        return {s, dx, dy, 6'b0, 3'd1, 3'd0, MY_X, MY_Y, pl};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] dx, input logic [2:0] dy, input logic [127:0] pl);
        int n;
        n = 0;
        ifc.req_valid   = 1'b1;
        ifc.req_dst_x   = dx;
        ifc.req_dst_y   = dy;
        ifc.req_payload = pl;
        while (!ifc.req_ready && n < 100) begin
            cyc(1);
            n++;
        end
        if (!ifc.req_ready) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout actual=ready0 required=ready1");
            ifc.req_valid = 1'b0;
            return;
        end
        if (!(dx == MY_X && dy == MY_Y)) begin
            sb.push_back(exp_flit(mseq, dx, dy, pl));
            mseq++;
        end
        cyc(1);
        ifc.req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sb.delete();
        mseq = 8'd0;
        cyc(1);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && inj_fire) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_fire actual=%h required=no_flit", data_out_4);
            end else begin
                check("flit_order", data_out_4, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.req_valid   = 1'b0;
        ifc.req_dst_x   = '0;
        ifc.req_dst_y   = '0;
        ifc.req_payload = '0;

        // reset state
        #12;
        check("rst_data_out", data_out_4, '0);
        check("rst_ready", 160'(ifc.req_ready), 160'd1);
        check("rst_fire", 160'(inj_fire), 160'd0);
        check("rst_starve", 160'(starve), 160'd0);
        check("rst_errlb", 160'(err_loopback), 160'd0);
        check("rst_count", 160'(inj_count), 160'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // single request, hand-computed flit
        net_busy = 4'b0000;
        send(3'd3, 3'd4, 128'hDEAD_BEEF_0000_0001);
        check("single_flit", data_out_4, {32'h0070_0215, 128'hDEAD_BEEF_0000_0001});
        check("single_fire", 160'(inj_fire), 160'd1);
        cyc(1);
        check("single_count", 160'(inj_count), 160'd1);
        check("single_idle", data_out_4, '0);

        // blocked injection and starvation
        net_busy = 4'b1111;
        send(3'd1, 3'd1, 128'h1111);
        held = data_out_4;
        check("blk_fire", 160'(inj_fire), 160'd0);
        cyc(15);
        check("starve_pre", 160'(starve), 160'd0);
        cyc(1);
        check("starve_set", 160'(starve), 160'd1);
        cyc(4);
        check("blk_hold", data_out_4, held);
        check("blk_fire20", 160'(inj_fire), 160'd0);
        net_busy = 4'b0111;
        #1;
        check("release_fire", 160'(inj_fire), 160'd1);
        cyc(1);
        check("starve_clr", 160'(starve), 160'd0);
        check("blk_count", 160'(inj_count), 160'd2);

        // fill out stage plus FIFO, then drain in order
        pulse_reset();
        net_busy = 4'b1111;
        for (int i = 0; i < 5; i++) send(3'(i), 3'd7, 128'(32'hA000 + i));
        check("full_ready", 160'(ifc.req_ready), 160'd0);
        net_busy = 4'b0000;
        cyc(8);
        check("fill_count", 160'(inj_count), 160'd5);
        check("fill_ready", 160'(ifc.req_ready), 160'd1);

        // loopback drop
        send(MY_X, MY_Y, 128'hBAD);
        check("lb_pulse", 160'(err_loopback), 160'd1);
        check("lb_noflit", data_out_4, '0);
        cyc(1);
        check("lb_pulse_end", 160'(err_loopback), 160'd0);
        check("lb_count", 160'(inj_count), 160'd5);

        // 300 back-to-back injections, seq wraps through 255
        pulse_reset();
        for (int i = 0; i < 300; i++) send(3'(i), 3'(i + 1), 128'(i));
        cyc(3);
        check("wrap_count", 160'(inj_count), 160'd300);

        // asynchronous reset with flits queued
        net_busy = 4'b1111;
        for (int i = 0; i < 4; i++) send(3'd6, 3'(i), 128'(i + 77));
        #2;
        reset = 1'b1;
        #1;
        check("amid_data", data_out_4, '0);
        check("amid_ready", 160'(ifc.req_ready), 160'd1);
        check("amid_count", 160'(inj_count), 160'd0);
        sb.delete();
        mseq = 8'd0;
        cyc(1);
        reset = 1'b0;
        net_busy = 4'b0000;
        send(3'd5, 3'd5, 128'hC0FFEE);
        check("post_rst_seq", 160'(data_out_4[159:152]), 160'd0);
        cyc(3);

        check("sb_drain", 160'(sb.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
